// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: per-stage stall/flush generation with a load-latency tracker
// covering loads that have left EX but whose data is not yet forwardable.
module pipe_stall_ctrl #(
    parameter int N_STAGES = 6,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_rs_re,
    input  logic                id_rt_re,
    input  logic [REG_AW-1:0]   id_rs_addr,
    input  logic [REG_AW-1:0]   id_rt_addr,
    input  logic                ex_is_load,
    input  logic                ex_wreg,
    input  logic [REG_AW-1:0]   ex_wd,
    input  logic                ex_busy,
    input  logic                mem_busy,
    input  logic                flush_req,
    output logic [N_STAGES-1:0] stall,
    output logic                flush,
    output logic                load_pending,
    output logic [15:0]         stall_cnt
);
    typedef enum logic {IDLE, TRACK} state_t;

    localparam logic [N_STAGES-1:0] ones = '1;

    state_t            state, state_n;
    logic [REG_AW-1:0] trk_wd, trk_wd_n;
    logic [2:0]        trk_cnt, trk_cnt_n;
    logic              ex_ld, id_req, ex_req, mem_req, depart;

    function automatic logic hit(input logic [REG_AW-1:0] a);
        return (a != '0) && ((id_rs_re && id_rs_addr == a) || (id_rt_re && id_rt_addr == a));
    endfunction

    assign ex_ld        = ex_is_load && ex_wreg && (ex_wd != '0);
    assign load_pending = (state == TRACK);
    assign id_req       = (ex_ld && hit(ex_wd)) || (load_pending && hit(trk_wd));
    assign ex_req       = ex_busy || (ex_ld && load_pending && trk_cnt > 3'd1);
    assign mem_req      = mem_busy;
    assign flush        = flush_req;

    // Highest requesting stage k holds stall[k:0]; reset and flush override everything.
    always_comb begin
        stall = mem_req ? ~(ones << 5) : ex_req ? ~(ones << 4) : id_req ? ~(ones << 3) : '0;
        if (!rst_n || flush_req)
            stall = '0;
    end

    assign depart = ex_ld && !stall[3] && !flush_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            trk_wd  <= '0;
            trk_cnt <= '0;
        end else begin
            state   <= state_n;
            trk_wd  <= trk_wd_n;
            trk_cnt <= trk_cnt_n;
        end
    end

    // Flush does not touch the tracker: a departed load is already beyond EX.
    always_comb begin
        state_n   = state;
        trk_wd_n  = trk_wd;
        trk_cnt_n = trk_cnt;
        if (LOAD_LAT > 1 && depart) begin
            state_n   = TRACK;
            trk_wd_n  = ex_wd;
            trk_cnt_n = 3'(LOAD_LAT - 1);
        end else if (state == TRACK && !mem_busy) begin
            trk_cnt_n = trk_cnt - 3'd1;
            state_n   = (trk_cnt == 3'd1) ? IDLE : TRACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall[0] && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks on two instances, LOAD_LAT=1 (d1) and LOAD_LAT=3 (d3),
// sharing one stimulus; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_pipe_stall_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    logic id_rs_re, id_rt_re, ex_is_load, ex_wreg, ex_busy, mem_busy, flush_req;
    logic [4:0] id_rs_addr, id_rt_addr, ex_wd;
    logic [5:0] stall1, stall3;
    logic flush1, flush3, lp1, lp3;
    logic [15:0] cnt1, cnt3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.N_STAGES(6), .REG_AW(5), .LOAD_LAT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .ex_is_load(ex_is_load),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_busy(ex_busy), .mem_busy(mem_busy),
        .flush_req(flush_req), .stall(stall1), .flush(flush1), .load_pending(lp1),
        .stall_cnt(cnt1));

    pipe_stall_ctrl #(.N_STAGES(6), .REG_AW(5), .LOAD_LAT(3)) d3 (
        .clk(clk), .rst_n(rst_n), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .ex_is_load(ex_is_load),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_busy(ex_busy), .mem_busy(mem_busy),
        .flush_req(flush_req), .stall(stall3), .flush(flush3), .load_pending(lp3),
        .stall_cnt(cnt3));

    task automatic clear_in();
        id_rs_re = 0; id_rt_re = 0; id_rs_addr = 0; id_rt_addr = 0;
        ex_is_load = 0; ex_wreg = 0; ex_wd = 0;
        ex_busy = 0; mem_busy = 0; flush_req = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        ex_is_load = 1; ex_wreg = 1; ex_wd = rd;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        next();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_in();
        ex_busy = 1;
        mem_busy = 1;
        #2;
        checks++;
        if (stall1 !== 6'b0 || stall3 !== 6'b0) begin
            errors++; $display("FAIL reset_stall got %b/%b want 000000", stall1, stall3);
        end
        checks++;
        if (lp1 !== 0 || lp3 !== 0 || cnt1 !== 16'd0 || cnt3 !== 16'd0) begin
            errors++; $display("FAIL reset_state lp %b/%b cnt %0d/%0d want 0", lp1, lp3, cnt1, cnt3);
        end
        do_reset();
    endtask

    task automatic test_load_lat1();
        do_reset();
        load(5'd1); id_rs_re = 1; id_rs_addr = 5'd1;
        @(negedge clk);
        checks++;
        if (stall1 !== 6'b000111) begin
            errors++; $display("FAIL lat1_stall got %b want 000111", stall1);
        end
        next();
        clear_in();
        @(negedge clk);
        checks++;
        if (stall1 !== 6'b0 || lp1 !== 0) begin
            errors++; $display("FAIL lat1_release stall %b lp %b want 000000 0", stall1, lp1);
        end
        checks++;
        if (cnt1 !== 16'd1) begin
            errors++; $display("FAIL lat1_cnt got %0d want 1", cnt1);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load(5'd3);
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b0 || lp3 !== 0) begin
            errors++; $display("FAIL lu_depart stall %b lp %b want 000000 0", stall3, lp3);
        end
        next();
        clear_in(); id_rs_re = 1; id_rs_addr = 5'd3;
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b000111 || lp3 !== 1) begin
            errors++; $display("FAIL lu_cycle1 stall %b lp %b want 000111 1", stall3, lp3);
        end
        next();
        clear_in(); id_rt_re = 1; id_rt_addr = 5'd3;
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b000111 || lp3 !== 1) begin
            errors++; $display("FAIL lu_cycle2 stall %b lp %b want 000111 1", stall3, lp3);
        end
        next();
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b0 || lp3 !== 0) begin
            errors++; $display("FAIL lu_cycle3 stall %b lp %b want 000000 0", stall3, lp3);
        end
        checks++;
        if (cnt3 !== 16'd2) begin
            errors++; $display("FAIL lu_cnt got %0d want 2", cnt3);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        load(5'd5);
        next();
        clear_in();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (stall3 !== 6'b011111 || lp3 !== 1) begin
                errors++; $display("FAIL mem_busy%0d stall %b lp %b want 011111 1", i, stall3, lp3);
            end
            next();
        end
        mem_busy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (lp3 !== (i < 2) || stall3 !== 6'b0) begin
                errors++; $display("FAIL mem_resume%0d lp %b stall %b want %b 000000", i, lp3, stall3, i < 2);
            end
            next();
        end
    endtask

    task automatic test_ex_busy_flush();
        do_reset();
        ex_busy = 1; load(5'd2); id_rs_re = 1; id_rs_addr = 5'd2;
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b001111 || stall1 !== 6'b001111) begin
            errors++; $display("FAIL exbusy_hazard got %b/%b want 001111", stall1, stall3);
        end
        #1 flush_req = 1;
        #1;
        checks++;
        if (stall3 !== 6'b0 || flush3 !== 1 || flush1 !== 1) begin
            errors++; $display("FAIL flush stall %b flush %b want 000000 1", stall3, flush3);
        end
        ex_busy = 0;
        next();
        clear_in();
        @(negedge clk);
        checks++;
        if (lp3 !== 0 || flush3 !== 0) begin
            errors++; $display("FAIL flush_blocks_depart lp %b flush %b want 0 0", lp3, flush3);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(5'd4);
        next();
        load(5'd6);
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b001111) begin
            errors++; $display("FAIL b2b_serialise got %b want 001111", stall3);
        end
        next();
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b0 || lp3 !== 1) begin
            errors++; $display("FAIL b2b_release stall %b lp %b want 000000 1", stall3, lp3);
        end
        next();
        clear_in(); id_rs_re = 1; id_rs_addr = 5'd6; id_rt_re = 1; id_rt_addr = 5'd4;
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b000111) begin
            errors++; $display("FAIL b2b_retrack got %b want 000111", stall3);
        end
        #1 id_rs_re = 0;
        #1;
        checks++;
        if (stall3 !== 6'b0) begin
            errors++; $display("FAIL b2b_old_wd got %b want 000000", stall3);
        end
    endtask

    task automatic test_r0();
        do_reset();
        load(5'd0); id_rs_re = 1; id_rt_re = 1;
        @(negedge clk);
        checks++;
        if (stall1 !== 6'b0 || stall3 !== 6'b0) begin
            errors++; $display("FAIL r0_stall got %b/%b want 000000", stall1, stall3);
        end
        next();
        @(negedge clk);
        checks++;
        if (lp3 !== 0 || stall3 !== 6'b0) begin
            errors++; $display("FAIL r0_track lp %b stall %b want 0 000000", lp3, stall3);
        end
    endtask

    task automatic test_reset_track();
        do_reset();
        load(5'd7);
        next();
        clear_in(); id_rs_re = 1; id_rs_addr = 5'd7;
        #1;
        checks++;
        if (stall3 !== 6'b000111 || lp3 !== 1) begin
            errors++; $display("FAIL rt_pre stall %b lp %b want 000111 1", stall3, lp3);
        end
        rst_n = 0;
        #1;
        checks++;
        if (stall3 !== 6'b0 || lp3 !== 0) begin
            errors++; $display("FAIL rt_async stall %b lp %b want 000000 0", stall3, lp3);
        end
        #1 rst_n = 1;
        next();
        @(negedge clk);
        checks++;
        if (stall3 !== 6'b0 || lp3 !== 0 || cnt3 !== 16'd0) begin
            errors++; $display("FAIL rt_post stall %b lp %b cnt %0d want 000000 0 0", stall3, lp3, cnt3);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_busy = 1;
        repeat (65534) next();
        checks++;
        if (cnt1 !== 16'hFFFE || cnt3 !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got %h/%h want fffe", cnt1, cnt3);
        end
        repeat (3) next();
        checks++;
        if (cnt1 !== 16'hFFFF || cnt3 !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h/%h want ffff", cnt1, cnt3);
        end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_load_lat1();
        test_load_use();
        test_mem_busy();
        test_ex_busy_flush();
        test_back_to_back();
        test_r0();
        test_reset_track();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 6, meaning stall vector width (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB); legal range 4..8.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, meaning cycles after a load leaves EX until its data is forwardable; legal range 1..7.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports id_rs_re, id_rt_re, input, 1 each, meaning ID reads rs / rt.
REQ-007 SHALL have ports id_rs_addr, id_rt_addr, input, REG_AW each, meaning ID source register numbers.
REQ-008 SHALL have ports ex_is_load, ex_wreg, input, 1 each, and ex_wd, input, REG_AW, meaning the EX instruction is a load / writes a register / its destination.
REQ-009 SHALL have ports ex_busy, mem_busy, input, 1 each, meaning multi-cycle EX op / data-memory wait.
REQ-010 SHALL have port flush_req, input, 1, meaning exception or redirect flush.
REQ-011 SHALL have port stall, output, N_STAGES, meaning per-stage hold.
REQ-012 SHALL have port flush, output, 1, meaning pipeline flush.
REQ-013 SHALL have port load_pending, output, 1, meaning tracker FSM is in TRACK.
REQ-014 SHALL have port stall_cnt, output, 16, meaning saturating count of cycles with stall[0]=1.

Function
REQ-015 SHALL define ex_ld = ex_is_load & ex_wreg & (ex_wd != 0).
REQ-016 SHALL define hit(a) = (id_rs_re & id_rs_addr==a) | (id_rt_re & id_rt_addr==a), with a != 0.
REQ-017 ID request SHALL be raised when ex_ld & hit(ex_wd), or when load_pending & hit(trk_wd).
REQ-018 EX request SHALL be raised when ex_busy, or when ex_ld & load_pending & trk_cnt > 1 (loads serialised).
REQ-019 MEM request SHALL be raised when mem_busy.
REQ-020 stall SHALL be combinational: highest requesting stage k gives stall[k:0] all 1 and stall[N_STAGES-1:k+1] all 0; no request gives all 0.
REQ-021 flush SHALL equal flush_req; when flush_req=1, stall SHALL be all 0 regardless of requests.
REQ-022 Tracker FSM SHALL have states IDLE and TRACK, with registers trk_wd (REG_AW) and trk_cnt (3 bits).
REQ-023 A load SHALL depart EX when ex_ld & !stall[3] & !flush_req.
REQ-024 When LOAD_LAT=1, the FSM SHALL remain in IDLE permanently.
REQ-025 With LOAD_LAT>1, on departure the FSM SHALL enter TRACK with trk_wd=ex_wd and trk_cnt=LOAD_LAT-1; this applies from both IDLE and TRACK.
REQ-026 In TRACK with no departure and mem_busy=0, trk_cnt SHALL decrement; on reaching 0 the FSM SHALL return to IDLE in that same edge.
REQ-027 In TRACK with mem_busy=1, trk_cnt SHALL hold.
REQ-028 flush_req=1 SHALL NOT clear the tracker, because the load is already past EX.
REQ-029 stall_cnt SHALL increment on each edge where stall[0]=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-030 rst_n=0 SHALL immediately force FSM=IDLE, trk_wd=0, trk_cnt=0, stall_cnt=0, load_pending=0, and stall=0.
REQ-031 On reset release mid-operation, no stall SHALL be generated from pre-reset state.

Verification
REQ-032 LOAD_LAT=1: ex_ld with ex_wd=1, id_rs_addr=1, id_rs_re=1 -> stall=6'b000111 for exactly 1 cycle; stall_cnt=1.
REQ-033 LOAD_LAT=3: load to r3 departs, then ID uses r3 on the next two cycles -> stall=6'b000111 on both cycles; load_pending falls after 2 edges; the third cycle is unstalled.
REQ-034 mem_busy=1 for 3 cycles during TRACK -> stall=6'b011111 on each, trk_cnt held, then tracking resumes.
REQ-035 Simultaneous ex_busy and an ID hazard -> stall=6'b001111; with flush_req also 1 -> stall=0, flush=1.
REQ-036 ex_wd=0 with ID reading r0 -> no stall; rst_n pulsed low during TRACK -> load_pending=0 and stall=0 immediately.
REQ-037 Force 65537 stalled cycles -> stall_cnt=16'hFFFF.
